latch_alu_out: RTL and testbench

Output-side pipeline register between the ALU and the writeback stage; it is the counterpart of the ALU input latch. Captures ALU result, flags, destination register and write enable through a valid/ready handshake. A two-entry skid buffer keeps alu_ready a pure register output, so there is no combinational path from wb_ready back to the ALU. Also provides a forwarding tap and a saturating writeback-stall counter.

---
 rtl/latch_alu_out.sv | 178 +++++++++++++++++
 tb/tb_latch_alu_out.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_alu_out.sv
// latch_alu_out
//   Output-side pipeline register between the ALU and writeback. Captures
//   result, flags, destination register and write enable through a
//   valid/ready handshake. A two-entry skid buffer (out + skid) keeps
//   alu_ready a pure register output, so wb_ready never reaches the ALU
//   combinationally. Also provides a forwarding tap on the youngest pending
//   entry and a saturating writeback-stall counter.
//
// Ports
//   clk, reset (async, active-low), flush (sync, highest priority)
//   alu_valid/alu_ready, alu_result, alu_flags, alu_rd, alu_wr_en  : ALU side
//   wb_valid/wb_ready, wb_result, wb_flags, wb_rd, wb_wr_en        : writeback
//   fwd_valid, fwd_rd, fwd_data   : forwarding tap (registers only)
//   stall_cnt                     : cycles with wb_valid=1 and wb_ready=0
module latch_alu_out #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned FLAG_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic [REG_W-1:0]  alu_rd,
    input  logic              alu_wr_en,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_result,
    output logic [FLAG_W-1:0] wb_flags,
    output logic [REG_W-1:0]  wb_rd,
    output logic              wb_wr_en,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              ready_q;
    logic [DATA_W-1:0] out_result, skid_result;
    logic [FLAG_W-1:0] out_flags,  skid_flags;
    logic [REG_W-1:0]  out_rd,     skid_rd;
    logic              out_wr_en,  skid_wr_en;

    logic accept, drain;
    logic load_out_in, load_out_skid, load_skid_in;
    logic in_wr_en;

    assign accept   = alu_valid & ready_q;
    assign drain    = wb_valid & wb_ready;
    // Writes to x0 are dropped at capture; result and flags are still kept.
    assign in_wr_en = alu_wr_en & (alu_rd != '0);

    always_comb begin
        state_nxt     = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid_in  = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt   = ONE;
                        load_out_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        load_out_in = 1'b1;
                    end else if (accept) begin
                        state_nxt    = FULL;
                        load_skid_in = 1'b1;
                    end else if (drain) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        state_nxt     = ONE;
                        load_out_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != FULL);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_result  <= '0;
            out_flags   <= '0;
            out_rd      <= '0;
            out_wr_en   <= 1'b0;
            skid_result <= '0;
            skid_flags  <= '0;
            skid_rd     <= '0;
            skid_wr_en  <= 1'b0;
        end else begin
            if (load_out_in) begin
                out_result <= alu_result;
                out_flags  <= alu_flags;
                out_rd     <= alu_rd;
                out_wr_en  <= in_wr_en;
            end else if (load_out_skid) begin
                out_result <= skid_result;
                out_flags  <= skid_flags;
                out_rd     <= skid_rd;
                out_wr_en  <= skid_wr_en;
            end
            if (load_skid_in) begin
                skid_result <= alu_result;
                skid_flags  <= alu_flags;
                skid_rd     <= alu_rd;
                skid_wr_en  <= in_wr_en;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (wb_valid && !wb_ready && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign alu_ready = ready_q;
    assign wb_valid  = (state != EMPTY);
    assign wb_result = out_result;
    assign wb_flags  = out_flags;
    assign wb_rd     = out_rd;
    // Data registers survive a flush, so the enable is qualified by valid.
    assign wb_wr_en  = out_wr_en & wb_valid;

    // Youngest valid entry: skid when FULL, out when ONE.
    always_comb begin
        fwd_valid = 1'b0;
        fwd_rd    = '0;
        fwd_data  = '0;
        unique case (state)
            ONE: begin
                fwd_valid = out_wr_en;
                fwd_rd    = out_rd;
                fwd_data  = out_result;
            end
            FULL: begin
                fwd_valid = skid_wr_en;
                fwd_rd    = skid_rd;
                fwd_data  = skid_result;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_latch_alu_out.sv
module tb_latch_alu_out;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              alu_valid;
    logic              alu_ready;
    logic [DATA_W-1:0] alu_result;
    logic [FLAG_W-1:0] alu_flags;
    logic [REG_W-1:0]  alu_rd;
    logic              alu_wr_en;
    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_result;
    logic [FLAG_W-1:0] wb_flags;
    logic [REG_W-1:0]  wb_rd;
    logic              wb_wr_en;
    logic              fwd_valid;
    logic [REG_W-1:0]  fwd_rd;
    logic [DATA_W-1:0] fwd_data;
    logic [CNT_W-1:0]  stall_cnt;

    latch_alu_out #(
        .DATA_W(DATA_W),
        .REG_W (REG_W),
        .FLAG_W(FLAG_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_result(alu_result),
        .alu_flags (alu_flags),
        .alu_rd    (alu_rd),
        .alu_wr_en (alu_wr_en),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_result (wb_result),
        .wb_flags  (wb_flags),
        .wb_rd     (wb_rd),
        .wb_wr_en  (wb_wr_en),
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data),
        .stall_cnt (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a FIFO of at most two entries, oldest at the front.
    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic [FLAG_W-1:0] flg;
        logic [REG_W-1:0]  rd;
        logic              wr;
    } ent_t;

    ent_t q[$];
    logic m_ready;
    int   m_cnt;
    int   n_vec;
    int   n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        ent_t f, b;
        chk("wb_valid", 32'(wb_valid), 32'(q.size() > 0));
        chk("alu_ready", 32'(alu_ready), 32'(m_ready));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        if (q.size() > 0) begin
            f = q[0];
            b = q[q.size()-1];
            chk("wb_result", wb_result, f.res);
            chk("wb_flags", 32'(wb_flags), 32'(f.flg));
            chk("wb_rd", 32'(wb_rd), 32'(f.rd));
            chk("wb_wr_en", 32'(wb_wr_en), 32'(f.wr));
            chk("fwd_valid", 32'(fwd_valid), 32'(b.wr));
            chk("fwd_rd", 32'(fwd_rd), 32'(b.rd));
            chk("fwd_data", fwd_data, b.res);
        end else begin
            chk("wb_wr_en_empty", 32'(wb_wr_en), 32'h0);
            chk("fwd_valid_empty", 32'(fwd_valid), 32'h0);
            chk("fwd_rd_empty", 32'(fwd_rd), 32'h0);
            chk("fwd_data_empty", fwd_data, 32'h0);
        end
    endtask

    // Drive one cycle of inputs, advance the model on the edge, then check.
    task automatic step(input logic v, input logic [DATA_W-1:0] r, input logic [REG_W-1:0] rd,
                        input logic we, input logic rdy, input logic fl);
        ent_t e;
        bit acc, drn;
        alu_valid  = v;
        alu_result = r;
        alu_flags  = r[FLAG_W-1:0] ^ rd[FLAG_W-1:0];
        alu_rd     = rd;
        alu_wr_en  = we;
        wb_ready   = rdy;
        flush      = fl;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            acc = v && m_ready;
            drn = (q.size() > 0) && rdy;
            if ((q.size() > 0) && !rdy && (m_cnt < CNT_MAX)) m_cnt++;
            if (drn) void'(q.pop_front());
            if (acc) begin
                e.res = r;
                e.flg = r[FLAG_W-1:0] ^ rd[FLAG_W-1:0];
                e.rd  = rd;
                e.wr  = we && (rd != 0);
                q.push_back(e);
            end
        end
        m_ready = (q.size() < 2);
        #1;
        check_all();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ready"}, 32'(alu_ready), 32'h0);
        chk({tag, "_wbv"}, 32'(wb_valid), 32'h0);
        chk({tag, "_res"}, wb_result, 32'h0);
        chk({tag, "_flg"}, 32'(wb_flags), 32'h0);
        chk({tag, "_rd"}, 32'(wb_rd), 32'h0);
        chk({tag, "_we"}, 32'(wb_wr_en), 32'h0);
        chk({tag, "_fwdv"}, 32'(fwd_valid), 32'h0);
        chk({tag, "_fwdrd"}, 32'(fwd_rd), 32'h0);
        chk({tag, "_fwdd"}, fwd_data, 32'h0);
        chk({tag, "_cnt"}, 32'(stall_cnt), 32'h0);
    endtask

    // Assert reset between edges, hold it across one edge, release it.
    task automatic do_reset(input string tag);
        alu_valid = 1'b1;
        wb_ready  = 1'b0;
        flush     = 1'b0;
        #1 reset  = 1'b0;
        #1;
        check_zero(tag);
        q.delete();
        m_ready = 1'b0;
        m_cnt   = 0;
        @(posedge clk);
        #1;
        check_zero({tag, "_held"});
        reset = 1'b1;
        #1;
        check_all();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_ready = 1'b0;
        m_cnt = 0;
        reset = 1'b1;
        flush = 1'b0;
        alu_valid = 1'b0;
        alu_result = '0;
        alu_flags = '0;
        alu_rd = '0;
        alu_wr_en = 1'b0;
        wb_ready = 1'b0;
        #2;
        do_reset("rst");

        // First edge after release raises alu_ready
        step(0, 0, 0, 0, 1, 0);
        chk("ready_after_rel", 32'(alu_ready), 32'h1);

        // Streaming, no bubbles
        step(1, 32'h11, 1, 1, 1, 0);
        chk("stream0", wb_result, 32'h11);
        step(1, 32'h22, 2, 1, 1, 0);
        chk("stream1", wb_result, 32'h22);
        step(1, 32'h33, 3, 1, 1, 0);
        chk("stream2", wb_result, 32'h33);
        chk("stream_ready", 32'(alu_ready), 32'h1);
        step(0, 0, 0, 0, 1, 0);
        chk("stream_cnt", 32'(stall_cnt), 32'h0);

        // Backpressure into FULL
        step(1, 32'hA, 3, 1, 0, 0);
        step(1, 32'hB, 4, 1, 0, 0);
        chk("bp_ready", 32'(alu_ready), 32'h0);
        chk("bp_res", wb_result, 32'hA);
        chk("bp_fwdrd", 32'(fwd_rd), 32'h4);
        chk("bp_fwdd", fwd_data, 32'hB);
        step(1, 32'hC, 5, 1, 0, 0);
        chk("bp_hold", wb_result, 32'hA);
        step(0, 0, 0, 0, 1, 0);
        chk("bp_drain", wb_result, 32'hB);
        chk("bp_ready_back", 32'(alu_ready), 32'h1);
        step(0, 0, 0, 0, 1, 0);
        chk("bp_empty", 32'(wb_valid), 32'h0);

        // Write to x0
        step(1, 32'hDEAD, 0, 1, 0, 0);
        chk("x0_we", 32'(wb_wr_en), 32'h0);
        chk("x0_fwdv", 32'(fwd_valid), 32'h0);
        chk("x0_res", wb_result, 32'hDEAD);

        // Flush in FULL with a valid input
        step(1, 32'h5, 7, 1, 0, 0);
        step(1, 32'h99, 9, 1, 1, 1);
        chk("fl_wbv", 32'(wb_valid), 32'h0);
        chk("fl_ready", 32'(alu_ready), 32'h1);
        chk("fl_fwdv", 32'(fwd_valid), 32'h0);
        step(0, 0, 0, 0, 1, 0);
        chk("fl_gone", 32'(wb_valid), 32'h0);

        // Stall counter saturation
        step(1, 32'h77, 6, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0);
        chk("sat", 32'(stall_cnt), 32'd15);
        step(0, 0, 0, 0, 0, 1);
        chk("sat_flush", 32'(stall_cnt), 32'd15);

        // Reset mid-operation with two entries held
        step(1, 32'h1, 1, 1, 0, 0);
        step(1, 32'h2, 2, 1, 0, 0);
        do_reset("rst_mid");
        step(0, 0, 0, 0, 1, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [REG_W-1:0] rd;
            rd = ($urandom_range(0, 3) == 0) ? '0 : REG_W'($urandom_range(1, 31));
            step(logic'($urandom_range(0, 3) != 0), $urandom, rd, logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 9) < 6), logic'($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
